// File: rtl/memory_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : memory_request_sequencer
// Brief    : Accepts one memory request at a time and routes it to ROM
//            (17-bit words) or RAM (16-bit words). It waits the configured
//            access latency, steers the return mux, captures the returned
//            word and pulses a single-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module memory_request_sequencer #(
   parameter int ROM_LATENCY = 1,
   parameter int RAM_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_space,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rom_en,
   output logic [15:0] rom_addr,
   output logic        ram_en,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        emux_select,
   input  logic [16:0] rdata_in,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [16:0] resp_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [3:0] C_ROM_LAT = 4'(ROM_LATENCY);
   localparam logic [3:0] C_RAM_LAT = 4'(RAM_LATENCY);

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [3:0]  r_cnt;
   logic        r_space;
   logic        r_write;
   logic        r_first;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_emux;
   logic [16:0] r_resp_data;

   logic        w_accept;
   logic        w_rom_write;
   logic        w_last;

   assign w_accept    = (r_state == S_IDLE) && req_valid;
   // A write aimed at ROM never touches memory; it completes immediately with an error.
   assign w_rom_write = ~req_space & req_write;
   assign w_last      = (r_cnt == 4'd1);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: accept, count down the access latency, then respond
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = w_rom_write ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (w_last) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State-decoded outputs: handshake, memory strobes and response flags
   always_comb begin
      req_ready  = 1'b0;
      rom_en     = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      resp_valid = 1'b0;
      resp_error = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
         end
         S_ACCESS: begin
            rom_en = ~r_space;
            ram_en = r_space;
            // The write strobe is a single pulse at the start of the access window.
            ram_we = r_space & r_write & r_first;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_error = ~r_space & r_write;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // Request latch, latency counter, return-mux select and response capture
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= 4'd0;
         r_space     <= 1'b0;
         r_write     <= 1'b0;
         r_first     <= 1'b0;
         r_addr      <= 16'd0;
         r_wdata     <= 16'd0;
         r_emux      <= 1'b0;
         r_resp_data <= 17'd0;
      end else if (w_accept) begin
         r_space <= req_space;
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_emux  <= req_space;
         r_first <= 1'b1;
         r_cnt   <= req_space ? C_RAM_LAT : C_ROM_LAT;
         if (w_rom_write) begin
            r_resp_data <= 17'd0;
         end
      end else if (r_state == S_ACCESS) begin
         r_first <= 1'b0;
         r_cnt   <= r_cnt - 4'd1;
         if (w_last) begin
            // RAM words arrive zero-extended from the mux, so no width handling here.
            r_resp_data <= r_write ? 17'd0 : rdata_in;
         end
      end
   end

   assign rom_addr    = r_addr;
   assign ram_addr    = r_addr;
   assign ram_wdata   = r_wdata;
   assign emux_select = r_emux;
   assign resp_data   = r_resp_data;

endmodule
`default_nettype wire
